sync_deframer: RTL and testbench

SYNC_DEFRAMER -- requirements
Module: sync_deframer

---
 rtl/sync_deframer.sv | 112 +++++++++++
 tb/tb_sync_deframer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_deframer.sv
// rtl/sync_deframer.sv - sync-nibble frame aligner producing one byte per 12-bit frame
module sync_deframer #(
    parameter logic [3:0] SYNC     = 4'b1011,
    parameter int         MISS_MAX = 2
) (
    input  logic       clk,
    input  logic       r,
    input  logic [3:0] q,
    output logic [7:0] data,
    output logic       valid,
    output logic       locked,
    output logic       err,
    output logic [7:0] frames
);

    typedef enum logic [1:0] {HUNT, HI, LO, CHK} state_t;

    localparam logic [1:0] MISS_LIM = 2'(MISS_MAX);

    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [1:0] miss, miss_n;
    logic [3:0] hi, hi_n;
    logic [7:0] data_n;
    logic       valid_n;
    logic       locked_n;
    logic       err_n;
    logic [7:0] frames_n;
    logic [1:0] miss_inc;

    assign miss_inc = miss + 2'd1;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state  <= HUNT;
            cnt    <= 2'd0;
            miss   <= 2'd0;
            hi     <= 4'h0;
            data   <= 8'h00;
            valid  <= 1'b0;
            locked <= 1'b0;
            err    <= 1'b0;
            frames <= 8'h00;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            miss   <= miss_n;
            hi     <= hi_n;
            data   <= data_n;
            valid  <= valid_n;
            locked <= locked_n;
            err    <= err_n;
            frames <= frames_n;
        end
    end

    // Every state but HUNT counts four window shifts, then acts on a fresh nibble in q.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        miss_n   = miss;
        hi_n     = hi;
        data_n   = data;
        valid_n  = 1'b0;
        locked_n = locked;
        err_n    = 1'b0;
        frames_n = frames;
        case (state)
            HUNT: begin
                cnt_n = 2'd0;
                if (q == SYNC) begin
                    state_n = HI;
                end
            end
            default: begin
                cnt_n = cnt + 2'd1;
                if (cnt == 2'd3) begin
                    cnt_n = 2'd0;
                    case (state)
                        HI: begin
                            hi_n    = q;
                            state_n = LO;
                        end
                        LO: begin
                            data_n  = {hi, q};
                            valid_n = 1'b1;
                            state_n = CHK;
                        end
                        default: begin
                            if (q == SYNC) begin
                                miss_n   = 2'd0;
                                locked_n = 1'b1;
                                frames_n = frames + 8'd1;
                                state_n  = HI;
                            end else if (miss_inc == MISS_LIM) begin
                                miss_n   = 2'd0;
                                locked_n = 1'b0;
                                err_n    = 1'b1;
                                state_n  = HUNT;
                            end else begin
                                // Flywheel: tolerate an isolated bad sync and keep framing.
                                miss_n  = miss_inc;
                                state_n = HI;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_sync_deframer.sv
// tb/tb_sync_deframer.sv - scoreboard bench for sync_deframer
module tb_sync_deframer;

    logic       clk;
    logic       r;
    logic [3:0] q;
    logic [7:0] data;
    logic       valid;
    logic       locked;
    logic       err;
    logic [7:0] frames;

    int checks;
    int failures;
    int err_seen;
    logic [7:0] exp_q[$];
    logic [7:0] exp_frames;

    sync_deframer #(.SYNC(4'b1011), .MISS_MAX(2)) dut (
        .clk(clk), .r(r), .q(q), .data(data), .valid(valid),
        .locked(locked), .err(err), .frames(frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte scoreboard: every valid strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (r) begin
            if (valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid data=%h required=no_valid", data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data !== e) begin
                        failures++;
                        $display("FAIL byte data=%h required=%h", data, e);
                    end
                end
            end
            if (err) err_seen++;
            if (valid && err) begin
                checks++;
                failures++;
                $display("FAIL valid_err_overlap valid=%b err=%b required=not_both", valid, err);
            end
        end
    end

    task automatic push_bit(input logic b);
        q = {q[2:0], b};
        @(posedge clk);
        #1;
    endtask

    task automatic send_nib(input logic [3:0] n);
        for (int i = 3; i >= 0; i--) push_bit(n[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
    endtask

    task automatic good_sync();
        send_nib(4'b1011);
        exp_frames = exp_frames + 8'd1;
    endtask

    task automatic test_reset();
        r = 1'b0;
        q = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({data, valid, locked, err, frames} !== 19'h0) begin
            failures++;
            $display("FAIL reset_state data=%h valid=%b locked=%b err=%b frames=%h required=all_zero",
                     data, valid, locked, err, frames);
        end
        r = 1'b1;
        exp_frames = 8'h00;
    endtask

    task automatic test_first_frame();
        send_nib(4'b1011);
        send_byte(8'hA5);
        checks++;
        if (valid !== 1'b1 || data !== 8'hA5 || locked !== 1'b0) begin
            failures++;
            $display("FAIL first_byte valid=%b data=%h locked=%b required=1/a5/0", valid, data, locked);
        end
        good_sync();
        checks++;
        if (locked !== 1'b1 || frames !== 8'd1) begin
            failures++;
            $display("FAIL first_lock locked=%b frames=%0d required=1/1", locked, frames);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        bytes[0] = 8'h3C;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i]);
            good_sync();
        end
        checks++;
        if (frames !== exp_frames || frames !== 8'd4 || err_seen !== 0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL back_to_back frames=%0d err_seen=%0d locked=%b required=4/0/1",
                     frames, err_seen, locked);
        end
    endtask

    task automatic test_flywheel();
        send_byte(8'h96);
        send_nib(4'b0000);
        checks++;
        if (locked !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL flywheel_miss locked=%b err=%b required=1/0", locked, err);
        end
        send_byte(8'h5A);
        good_sync();
        // A second isolated miss must be tolerated only if the first was cleared.
        send_byte(8'h81);
        send_nib(4'b0000);
        send_byte(8'h42);
        good_sync();
        checks++;
        if (locked !== 1'b1 || err_seen !== 0 || frames !== exp_frames) begin
            failures++;
            $display("FAIL flywheel_recover locked=%b err_seen=%0d frames=%0d required=1/0/%0d",
                     locked, err_seen, frames, exp_frames);
        end
    endtask

    task automatic test_loss();
        send_byte(8'h11);
        send_nib(4'b0000);
        send_byte(8'h22);
        send_nib(4'b0000);
        checks++;
        if (err !== 1'b1 || locked !== 1'b0) begin
            failures++;
            $display("FAIL loss err=%b locked=%b required=1/0", err, locked);
        end
        push_bit(1'b0);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_pulse_width err=%b required=0", err);
        end
        for (int i = 0; i < 11; i++) push_bit(1'b0);
        send_nib(4'b1011);
        send_byte(8'h77);
        checks++;
        if (locked !== 1'b0 || data !== 8'h77) begin
            failures++;
            $display("FAIL resync_byte locked=%b data=%h required=0/77", locked, data);
        end
        good_sync();
        checks++;
        if (locked !== 1'b1 || frames !== exp_frames || err_seen !== 1) begin
            failures++;
            $display("FAIL relock locked=%b frames=%0d err_seen=%0d required=1/%0d/1",
                     locked, frames, err_seen, exp_frames);
        end
    endtask

    task automatic test_wrap();
        while (exp_frames != 8'hFF) begin
            send_byte(8'($urandom));
            good_sync();
        end
        checks++;
        if (frames !== 8'hFF) begin
            failures++;
            $display("FAIL frames_255 frames=%0d required=255", frames);
        end
        send_byte(8'h69);
        good_sync();
        checks++;
        if (frames !== 8'h00 || locked !== 1'b1) begin
            failures++;
            $display("FAIL frames_wrap frames=%0d locked=%b required=0/1", frames, locked);
        end
    endtask

    task automatic test_reset_mid();
        send_nib(4'hE);
        push_bit(1'b1);
        push_bit(1'b0);
        #2;
        r = 1'b0;
        #1;
        checks++;
        if ({data, valid, locked, err, frames} !== 19'h0) begin
            failures++;
            $display("FAIL async_reset data=%h valid=%b locked=%b err=%b frames=%h required=all_zero",
                     data, valid, locked, err, frames);
        end
        q = 4'h0;
        @(posedge clk);
        #1;
        r = 1'b1;
        exp_frames = 8'h00;
        send_nib(4'b1011);
        send_byte(8'hC3);
        checks++;
        if (valid !== 1'b1 || data !== 8'hC3 || locked !== 1'b0 || frames !== 8'h00) begin
            failures++;
            $display("FAIL post_reset_byte valid=%b data=%h locked=%b frames=%0d required=1/c3/0/0",
                     valid, data, locked, frames);
        end
        push_bit(1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        err_seen = 0;
        r = 1'b0;
        q = 4'h0;
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_flywheel();
        test_loss();
        test_wrap();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0 || err_seen != 1) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d err_seen=%0d required=0/1", exp_q.size(), err_seen);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
